// File: rtl/stopwatch_btn_ctrl_if.sv
// Button/command bundle between the front panel and stopwatch_btn_ctrl.
// master = panel/bench side (drives raw buttons), slave = controller side.
`timescale 1ns/1ps
interface stopwatch_btn_ctrl_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_midstop;
  logic       start_p;
  logic       stop_p;
  logic       midstop_p;
  logic       clr_p;
  logic [1:0] mode;

  modport master (
    output btn_start, btn_stop, btn_midstop,
    input  start_p, stop_p, midstop_p, clr_p, mode
  );

  modport slave (
    input  btn_start, btn_stop, btn_midstop,
    output start_p, stop_p, midstop_p, clr_p, mode
  );
endinterface

// File: rtl/stopwatch_btn_ctrl.sv
// Sync + debounce three buttons, arbitrate presses through a run-mode FSM; press->pulse DEBOUNCE_CYCLES+3 clocks, no backpressure.
// Long stop-press clear (clr_p) exists only when STOPWATCH_LONGPRESS_CLEAR_EN is defined.
`timescale 1ns/1ps
module stopwatch_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 200000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stopwatch_btn_ctrl_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               B_START  = 0;
  localparam int               B_MID    = 1;
  localparam int               B_STOP   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LAP     = 2'd2,
    STOPPED = 2'd3
  } mode_e;

  logic [2:0]       raw;
  logic [2:0]       s1_q, s1_d;
  logic [2:0]       s2_q, s2_d;
  logic [2:0]       db_q, db_d;
  logic [2:0]       db_prev_q, db_prev_d;
  logic [2:0]       evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  mode_e mode_q, mode_d;
  logic  start_p_q, start_p_d;
  logic  stop_p_q, stop_p_d;
  logic  midstop_p_q, midstop_p_d;
  logic  hold_fire;

  assign raw = {bus.btn_stop, bus.btn_midstop, bus.btn_start};

  // Counter only advances while the synced level disagrees with db; any agreement resets it.
  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    evt_d     = db_q & ~db_prev_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      evt_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      evt_q     <= evt_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              clr_p_q, clr_p_d;

  // Saturating at HOLD_LAST; the mode gate stops a re-fire once we are back in IDLE.
  always_comb begin
    hold_d = hold_q;
    if (!db_q[B_STOP]) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LAST && mode_q == STOPPED) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  assign hold_fire = (mode_q == STOPPED) && (hold_q == HOLD_LAST);

  always_comb begin
    clr_p_d = hold_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      clr_p_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      clr_p_q <= clr_p_d;
    end
  end

  assign bus.clr_p = clr_p_q;
`else
  logic unused_long;
  assign unused_long = (LONG_CYCLES > 0);
  assign hold_fire   = 1'b0;
  assign bus.clr_p   = 1'b0;
`endif

  // Only the highest-priority event of a cycle is looked at; losers are dropped.
  always_comb begin
    mode_d      = mode_q;
    start_p_d   = 1'b0;
    stop_p_d    = 1'b0;
    midstop_p_d = 1'b0;
    if (hold_fire) begin
      mode_d = IDLE;
    end else if (evt_q[B_STOP]) begin
      if (mode_q == RUN || mode_q == LAP) begin
        mode_d   = STOPPED;
        stop_p_d = 1'b1;
      end
    end else if (evt_q[B_MID]) begin
      if (mode_q == RUN) begin
        mode_d      = LAP;
        midstop_p_d = 1'b1;
      end else if (mode_q == LAP) begin
        mode_d      = RUN;
        midstop_p_d = 1'b1;
      end
    end else if (evt_q[B_START]) begin
      if (mode_q == IDLE || mode_q == STOPPED) begin
        mode_d    = RUN;
        start_p_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= IDLE;
      start_p_q   <= 1'b0;
      stop_p_q    <= 1'b0;
      midstop_p_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      start_p_q   <= start_p_d;
      stop_p_q    <= stop_p_d;
      midstop_p_q <= midstop_p_d;
    end
  end

  assign bus.start_p   = start_p_q;
  assign bus.stop_p    = stop_p_q;
  assign bus.midstop_p = midstop_p_q;
  assign bus.mode      = mode_q;

  a_cmd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({start_p_q, stop_p_q, midstop_p_q}));

endmodule

// File: doc/stopwatch_btn_ctrl.md
Name: stopwatch_btn_ctrl

Overview:
Button-conditioning and mode-control stage directly upstream of the stopwatch counter. It synchronizes and debounces the raw start, stop and midstop push-buttons, detects presses, and arbitrates them through a run-mode FSM. It emits one-clock command pulses to the counter only for legal transitions. Runs in the 100 MHz domain, ahead of the 100 Hz counter clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, clock cycles a synchronized input must hold a new level before it is accepted (10 ms at 100 MHz); minimum 2.
LONG_CYCLES, 200000000, stop-button hold time for a clear request (2 s); used only with the optional feature.

Ports:
clk  input  1  main clock, posedge active, 100 MHz
rst_n  input  1  asynchronous reset, active LOW
btn_start  input  1  raw start button, active HIGH, asynchronous to clk
btn_stop  input  1  raw stop button, active HIGH, asynchronous
btn_midstop  input  1  raw midstop button, active HIGH, asynchronous
start_p  output  1  one-clock start command
stop_p  output  1  one-clock stop command
midstop_p  output  1  one-clock midstop toggle command
mode  output  2  FSM state: 0 IDLE, 1 RUN, 2 LAP, 3 STOPPED
clr_p  output  1  one-clock clear request; constant 0 without the optional feature

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, debounced levels and counters go to 0. mode=IDLE. All pulse outputs are 0.
- Synchronizer: each button passes through a 2-FF synchronizer. A button rising before edge t appears at s2 after edge t+1.
- Debounce, per button:
  - If s2 equals the debounced level db, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with s2 still differing, db takes s2 and the counter clears.
  - Any bounce back to db clears the counter, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Counter width is $clog2(DEBOUNCE_CYCLES). It never wraps.
- Press event: db rising edge, using a registered previous db. Release is ignored.
- Latency: a clean press stable from cycle t gives its output pulse high for exactly one cycle, at cycle t+DEBOUNCE_CYCLES+3.
- Arbitration: events arriving in the same cycle are resolved with priority stop > midstop > start. Only the winning event is considered. Losers are discarded, not queued.
- FSM transitions (each transition emits its pulse in the same registered cycle as the mode update):
  - IDLE + start -> RUN, start_p.
  - RUN + midstop -> LAP, midstop_p.
  - LAP + midstop -> RUN, midstop_p.
  - RUN or LAP + stop -> STOPPED, stop_p.
  - STOPPED + start -> RUN, start_p.
- Illegal events produce no pulse and no state change:
  - start in RUN or LAP.
  - stop in IDLE or STOPPED.
  - midstop in IDLE or STOPPED.
- A held button produces exactly one event. It must be released (debounced low) before it can produce another.
- At most one of start_p, stop_p, midstop_p is high in any cycle.
- Reset mid-debounce or mid-pulse aborts immediately. No pulse is emitted after rst_n deasserts until a new full debounce completes.

Optional Feature:
Macro: STOPWATCH_LONGPRESS_CLEAR_EN.
Defined:
- A hold counter runs while the debounced stop level is high and mode is STOPPED.
- When it reaches LONG_CYCLES-1, clr_p pulses for one cycle, mode returns to IDLE, and the counter saturates until stop is released.
- Releasing stop clears the counter.
- Pressing stop in IDLE does nothing.
Undefined:
- No hold counter is synthesized.
- clr_p is tied to 0.
- STOPPED is left only by start.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4 and LONG_CYCLES=16.
- Reset: hold rst_n low with buttons toggling -> all outputs 0, mode=0. After release with no input, no pulse for 50 cycles.
- Clean press: btn_start high from cycle 10 for 20 cycles in IDLE -> start_p high only in cycle 17, mode=1 from cycle 17. Release and wait: no second pulse.
- Bounce rejection: btn_midstop pulses high for 3 cycles, low 1, high 3, repeated, in RUN -> no midstop_p, mode stays 1. Then a stable 10-cycle press -> one midstop_p, mode=2. Another press -> mode=1.
- Simultaneous: btn_start and btn_stop rise in the same cycle while in RUN -> only stop_p, mode=3. Next start press -> start_p, mode=1.
- Illegal press: btn_stop pressed in IDLE -> no pulse, mode=0. btn_start pressed in RUN -> no pulse.
- Long press, with the macro defined: in STOPPED, hold btn_stop for 30 cycles -> clr_p once, 16 cycles after stop debounces high, then mode=0. Same run without the macro -> clr_p stays 0 and mode stays 3.
